rr_mux: RTL and testbench

RR_MUX -- requirements
Module: rr_mux

---
 rtl/rr_mux_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/rr_mux.sv | 135 +++++++++++++
 tb/tb_rr_mux.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin mux and its arbiter.
// The packet-lock state type is only used when RR_MUX_PKT_LOCK_EN is defined.
package rr_mux_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } lock_state_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches i_req upward from i_ptr with wrap-around and
// returns a one-hot grant plus the granted index.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned SelW = sel_width(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [SelW-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [SelW-1:0] o_idx,
  output logic            o_any
);

  logic [SelW-1:0] w_cand;

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    // Walk from the farthest offset back to i_ptr so the nearest request wins.
    for (int off = int'(N) - 1; off >= 0; off--) begin
      w_cand = SelW'((32'(i_ptr) + 32'(off)) % N);
      if (i_req[w_cand]) begin
        o_gnt         = '0;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
        o_any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux.sv
// N-to-1 round-robin valid/ready mux with a registered output stage.
// Define RR_MUX_PKT_LOCK_EN to add in_last/out_last and hold the grant for a whole packet.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0][W-1:0]   in_data,
  input  logic [N-1:0]          in_valid,
  output logic [N-1:0]          in_ready,
`ifdef RR_MUX_PKT_LOCK_EN
  input  logic [N-1:0]          in_last,
  output logic                  out_last,
`endif
  output logic [W-1:0]          out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [$clog2(N)-1:0]  out_sel
);

  localparam int unsigned SelW = sel_width(N);

  logic [N-1:0]    w_arb_gnt;
  logic [SelW-1:0] w_arb_idx;
  logic            w_arb_any;
  logic [N-1:0]    w_gnt;
  logic [SelW-1:0] w_idx;
  logic            w_any;
  logic            w_load;
  logic            w_xfer;
  logic [SelW-1:0] w_ptr_next;

  logic [SelW-1:0] r_ptr;
  logic [W-1:0]    r_out_data;
  logic [SelW-1:0] r_out_sel;
  logic            r_out_valid;

  rr_arbiter #(
    .N    (N),
    .SelW (SelW)
  ) u_arb (
    .i_req (in_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

`ifdef RR_MUX_PKT_LOCK_EN
  lock_state_e     r_state;
  lock_state_e     w_state_next;
  logic [SelW-1:0] r_lock_ch;
  logic [SelW-1:0] w_lock_ch_next;
  logic            r_out_last;

  // While locked the arbiter is bypassed; an idle locked channel grants nobody.
  always_comb begin
    w_gnt = w_arb_gnt;
    w_idx = w_arb_idx;
    w_any = w_arb_any;
    if (r_state == StLocked) begin
      w_gnt            = '0;
      w_gnt[r_lock_ch] = in_valid[r_lock_ch];
      w_idx            = r_lock_ch;
      w_any            = in_valid[r_lock_ch];
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_lock_ch_next = r_lock_ch;
    if (w_xfer) begin
      case (r_state)
        StIdle: begin
          if (!in_last[w_idx]) begin
            w_state_next   = StLocked;
            w_lock_ch_next = w_idx;
          end
        end
        StLocked: begin
          if (in_last[w_idx]) w_state_next = StIdle;
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_lock_ch  <= '0;
      r_out_last <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_lock_ch <= w_lock_ch_next;
      if (w_xfer) r_out_last <= in_last[w_idx];
    end
  end

  assign out_last = r_out_last;
`else
  assign w_gnt = w_arb_gnt;
  assign w_idx = w_arb_idx;
  assign w_any = w_arb_any;
`endif

  assign w_load     = !r_out_valid || out_ready;
  assign w_xfer     = w_any && w_load && !rst;
  assign in_ready   = (w_load && !rst) ? w_gnt : '0;
  assign w_ptr_next = (w_idx == SelW'(N - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_ptr       <= w_ptr_next;
      r_out_data  <= in_data[w_idx];
      r_out_sel   <= w_idx;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux: a 4x32 instance for the main function and a 16x8
// instance for wide-index wrap; packet-lock cases build with RR_MUX_PKT_LOCK_EN.
module tb_rr_mux;

  logic             clk;
  logic             rst;
  logic [3:0][31:0] in_data;
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_sel;

  logic             rst16;
  logic [15:0][7:0] in_data16;
  logic [15:0]      in_valid16;
  logic [15:0]      in_ready16;
  logic [7:0]       out_data16;
  logic             out_valid16;
  logic             out_ready16;
  logic [3:0]       out_sel16;

`ifdef RR_MUX_PKT_LOCK_EN
  logic [3:0]       in_last;
  logic             out_last;
  logic [15:0]      in_last16;
  logic             out_last16;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  rr_mux #(
    .W (32),
    .N (4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef RR_MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  rr_mux #(
    .W (8),
    .N (16)
  ) u_dut16 (
    .clk       (clk),
    .rst       (rst16),
    .in_data   (in_data16),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
`ifdef RR_MUX_PKT_LOCK_EN
    .in_last   (in_last16),
    .out_last  (out_last16),
`endif
    .out_data  (out_data16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .out_sel   (out_sel16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    out_ready   = 1'b1;
    in_valid    = 4'hF;
    for (int i = 0; i < 4; i++) in_data[i] = 32'h1000 + 32'(i);
    rst16       = 1'b1;
    out_ready16 = 1'b1;
    in_valid16  = '0;
    for (int i = 0; i < 16; i++) in_data16[i] = 8'h40 + 8'(i);
`ifdef RR_MUX_PKT_LOCK_EN
    in_last   = 4'hF;
    in_last16 = '1;
`endif
    #1;
    check("rst_in_ready", 64'(in_ready), 64'h0);
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_sel", 64'(out_sel), 64'h0);

    // All channels valid: one beat per cycle, sel 0,1,2,3,0
    rst = 1'b0;
    #1;
    check("rr_first_ready", 64'(in_ready), 64'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_sel", 64'(out_sel), 64'(k % 4));
      check("rr_data", 64'(out_data), 64'(32'h1000 + 32'(k % 4)));
      check("rr_valid", 64'(out_valid), 64'h1);
    end

    // Only ch2 valid; first beat moves ptr to 3, second proves the wrap search
    in_valid   = 4'b0100;
    in_data[2] = 32'h11;
    tick();
    check("ch2_sel_a", 64'(out_sel), 64'h2);
    in_data[2] = 32'hA5;
    #1;
    check("wrap_ready", 64'(in_ready), 64'h4);
    tick();
    check("wrap_data", 64'(out_data), 64'hA5);
    check("wrap_sel", 64'(out_sel), 64'h2);

    // No requests: no ready, output drains, ptr stays at 3
    in_valid = 4'b0000;
    #1;
    check("idle_ready", 64'(in_ready), 64'h0);
    tick();
    check("idle_valid", 64'(out_valid), 64'h0);
    check("idle_data_hold", 64'(out_data), 64'hA5);
    in_valid   = 4'hF;
    in_data[2] = 32'h1002;
    #1;
    check("ptr_kept", 64'(in_ready), 64'h8);

    // Stall: 3 cycles out_ready=0 hold the beat, then accept and reload together
    out_ready = 1'b0;
    tick();
    check("stall_load_sel", 64'(out_sel), 64'h3);
    for (int k = 0; k < 3; k++) begin
      check("stall_ready", 64'(in_ready), 64'h0);
      tick();
      check("stall_sel", 64'(out_sel), 64'h3);
      check("stall_data", 64'(out_data), 64'h1003);
      check("stall_valid", 64'(out_valid), 64'h1);
    end
    out_ready = 1'b1;
    #1;
    check("resume_ready", 64'(in_ready), 64'h1);
    tick();
    check("resume_sel", 64'(out_sel), 64'h0);
    check("resume_valid", 64'(out_valid), 64'h1);

    in_valid = 4'b0000;
    tick();
    check("drain_valid", 64'(out_valid), 64'h0);

    // Reset while holding a beat and ch1 still presenting
    in_valid = 4'b0010;
    tick();
    check("pre_rst_sel", 64'(out_sel), 64'h1);
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    check("midrst_ready", 64'(in_ready), 64'h0);
    tick();
    check("midrst_valid", 64'(out_valid), 64'h0);
    check("midrst_sel", 64'(out_sel), 64'h0);
    check("midrst_data", 64'(out_data), 64'h0);
    rst       = 1'b0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    #1;
    check("midrst_ptr0", 64'(in_ready), 64'h1);

`ifdef RR_MUX_PKT_LOCK_EN
    // ch0 3-beat packet with ch1 waiting: ch1 only after ch0's last beat
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    in_valid   = 4'b0011;
    in_last    = 4'b0010;
    in_data[0] = 32'hB1;
    #1;
    check("lock_ready1", 64'(in_ready), 64'h1);
    tick();
    check("lock_sel1", 64'(out_sel), 64'h0);
    check("lock_data1", 64'(out_data), 64'hB1);
    check("lock_last1", 64'(out_last), 64'h0);
    in_valid = 4'b0010;
    #1;
    check("lock_gap_ready", 64'(in_ready), 64'h0);
    tick();
    check("lock_gap_valid", 64'(out_valid), 64'h0);
    in_valid   = 4'b0011;
    in_data[0] = 32'hB2;
    #1;
    check("lock_ready2", 64'(in_ready), 64'h1);
    tick();
    check("lock_data2", 64'(out_data), 64'hB2);
    in_last    = 4'b0011;
    in_data[0] = 32'hB3;
    tick();
    check("lock_data3", 64'(out_data), 64'hB3);
    check("lock_last3", 64'(out_last), 64'h1);
    #1;
    check("unlock_ready", 64'(in_ready), 64'h2);
    tick();
    check("unlock_sel", 64'(out_sel), 64'h1);
    check("unlock_data", 64'(out_data), 64'h1001);
`endif

    // 16 channels, 8-bit data: sel 0..15 then wrap to 0
    rst16      = 1'b0;
    in_valid16 = '1;
    for (int k = 0; k < 17; k++) begin
      tick();
      check("n16_sel", 64'(out_sel16), 64'(k % 16));
      check("n16_data", 64'(out_data16), 64'(8'h40 + 8'(k % 16)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
